// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state type and bus-width constants for the Wishbone data RAM
package wb_pkg;
  localparam int WB_XLEN = 32;
  localparam int WB_SEL_W = WB_XLEN / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_slave_state_t;
endpackage

// File: rtl/wb_ram_array.sv
// wb_ram_array: single-port word array with byte-lane write enables and registered read
// Ports: clk; en (capture read word); be (per-byte write enable); addr (word index); wdata; rdata (registered).
module wb_ram_array #(
  parameter int XLEN = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = XLEN / 8
) (
  input  logic            clk,
  input  logic            en,
  input  logic [SW-1:0]   be,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < SW; i++)
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone classic slave backing the core data bus with on-chip byte-writable RAM
// Ports: clk, rst_n (async active-low); cyc, stb, we, adr, sel, dat_w from the master;
//        dat_r (full word, valid only with ack), ack and err (one-cycle pulses) back to it.
// Optional macro WB_DATA_RAM_ERR_EN: out-of-window address or empty sel answers with err.
module wb_data_ram import wb_pkg::*; #(
  parameter int XLEN = WB_XLEN,
  parameter int DEPTH = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic            stb,
  input  logic            we,
  input  logic [XLEN-1:0] adr,
  input  logic [SW-1:0]   sel,
  input  logic [XLEN-1:0] dat_w,
  output logic [XLEN-1:0] dat_r,
  output logic            ack,
  output logic            err
);
  wb_slave_state_t state;
  logic [XLEN-1:0] adr_q, dat_q, adr_c, dat_c, ram_q;
  logic [SW-1:0] sel_q, sel_c;
  logic we_q, we_c, go_resp, bad, unused_bits;
  logic [3:0] cnt;
  // With zero wait states the RAM access happens on the capture edge itself,
  // so the live bus feeds the array while idle and the latches afterwards.
  always_comb begin
    adr_c = state == IDLE ? adr : adr_q;
    dat_c = state == IDLE ? dat_w : dat_q;
    sel_c = state == IDLE ? sel : sel_q;
    we_c = state == IDLE ? we : we_q;
    go_resp = (state == IDLE && cyc && stb && WAIT_STATES == 0) ||
              (state == WAIT && cyc && cnt == 4'd1);
  end
`ifdef WB_DATA_RAM_ERR_EN
  assign bad = (adr_c[XLEN-1:AW+2] != BASE_ADDR[XLEN-1:AW+2]) || sel_c == '0;
`else
  assign bad = 1'b0;
`endif
  assign unused_bits = ^{adr_c[1:0], adr_c[XLEN-1:AW+2], BASE_ADDR};
  wb_ram_array #(.XLEN(XLEN), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .en(go_resp),
    .be({SW{go_resp && we_c && !bad}} & sel_c),
    .addr(adr_c[AW+1:2]),
    .wdata(dat_c),
    .rdata(ram_q)
  );
  assign dat_r = ack ? ram_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
    end else begin
      ack <= go_resp && !bad;
      err <= go_resp && bad;
      case (state)
        IDLE: if (cyc && stb) begin
          adr_q <= adr;
          dat_q <= dat_w;
          sel_q <= sel;
          we_q <= we;
          cnt <= 4'(WAIT_STATES);
          state <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          if (!cyc) state <= IDLE;
          else if (cnt == 4'd1) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram: directed self-checking bench for wb_data_ram with 0 and 3 wait states
module tb_wb_data_ram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cyc [2], stb [2], we [2];
  logic [31:0] adr [2], dat_w [2];
  logic [3:0] sel [2];
  logic [31:0] dr0, dr3;
  logic ack0, ack3, err0, err3;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  wb_data_ram #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .adr(adr[0]),
    .sel(sel[0]), .dat_w(dat_w[0]), .dat_r(dr0), .ack(ack0), .err(err0)
  );
  wb_data_ram #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .adr(adr[1]),
    .sel(sel[1]), .dat_w(dat_w[1]), .dat_r(dr3), .ack(ack3), .err(err3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // One transfer on instance d; after capture the bus fields are scrambled to
  // show only latched values are used. Returns data, cycles to response, flags.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat,
                      output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_w[d] = wd;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    for (int i = 1; i <= 20 && !got_ack && !got_err; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        stb[d] = 1'b0; adr[d] = ~a; dat_w[d] = ~wd; sel[d] = ~s; we[d] = ~w;
      end
      lat = i;
      got_ack = d == 0 ? ack0 : ack3;
      got_err = d == 0 ? err0 : err3;
      rd = d == 0 ? dr0 : dr3;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask
  task automatic wr(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                    input string tag);
    logic [31:0] rd;
    int lat;
    logic ga, ge;
    xfer(d, 1'b1, a, s, wd, rd, lat, ga, ge);
    chk({tag, "_ack"}, 32'(ga), 32'd1);
    chk({tag, "_lat"}, 32'(lat), d == 0 ? 32'd1 : 32'd4);
  endtask
  task automatic rdc(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp,
                     input string tag);
    logic [31:0] rd;
    int lat;
    logic ga, ge;
    xfer(d, 1'b0, a, s, 32'h0, rd, lat, ga, ge);
    chk({tag, "_ack"}, 32'(ga), 32'd1);
    chk({tag, "_data"}, rd, exp);
  endtask
  initial begin
    logic [31:0] rd;
    int lat;
    logic ga, ge, seen;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; sel[i] = '0; dat_w[i] = '0;
    end
    #12;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_dr0", dr0, 32'd0);
    chk("rst_ack3", 32'(ack3), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, "w10");
    @(posedge clk); #1;
    chk("ack_pulse0", 32'(ack0), 32'd0);
    chk("dr_idle0", dr0, 32'd0);
    rdc(0, 32'h10, 4'hF, 32'hDEADBEEF, "r10");
    rdc(0, 32'h10, 4'h1, 32'hDEADBEEF, "r10_sel1");
    wr(0, 32'h20, 4'hF, 32'h00000000, "w20_clr");
    wr(0, 32'h20, 4'h1, 32'h000000AB, "w20_b0");
    rdc(0, 32'h20, 4'hF, 32'h000000AB, "r20_a");
    wr(0, 32'h20, 4'hC, 32'h12340000, "w20_hi");
    rdc(0, 32'h20, 4'hF, 32'h123400AB, "r20_b");
    wr(0, 32'h0, 4'hF, 32'hCAFEF00D, "w00");
    xfer(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, rd, lat, ga, ge);
`ifdef WB_DATA_RAM_ERR_EN
    chk("sel0_err", 32'(ge), 32'd1);
    chk("sel0_ack", 32'(ga), 32'd0);
`else
    chk("sel0_ack", 32'(ga), 32'd1);
    chk("sel0_err", 32'(ge), 32'd0);
`endif
    rdc(0, 32'h20, 4'hF, 32'h123400AB, "r20_sel0");
    xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, rd, lat, ga, ge);
`ifdef WB_DATA_RAM_ERR_EN
    chk("oor_err", 32'(ge), 32'd1);
    chk("oor_ack", 32'(ga), 32'd0);
    chk("oor_data", rd, 32'd0);
`else
    chk("oor_ack", 32'(ga), 32'd1);
    chk("oor_err", 32'(ge), 32'd0);
    chk("oor_alias", rd, 32'hCAFEF00D);
`endif
    wr(1, 32'h40, 4'hF, 32'h11112222, "w40_ws3");
    @(posedge clk); #1;
    chk("ack_pulse3", 32'(ack3), 32'd0);
    rdc(1, 32'h40, 4'hF, 32'h11112222, "r40_ws3");
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; dat_w[1] = 32'h99999999;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    seen = ack3;
    @(posedge clk); #1;
    cyc[1] = 1'b0;
    seen |= ack3;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= ack3;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    rdc(1, 32'h40, 4'hF, 32'h11112222, "r40_abort");
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; dat_w[1] = 32'h55555555;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack3), 32'd0);
    chk("rst_mid_dr", dr3, 32'd0);
    cyc[1] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= ack3;
    end
    chk("rst_mid_no_ack", 32'(seen), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rdc(1, 32'h40, 4'hF, 32'h11112222, "r40_rst");
    rdc(0, 32'h10, 4'hF, 32'hDEADBEEF, "r10_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
